// File: rtl/alu_operand_sequencer.sv
// Operand/operation entry front-end for the 4-bit ALU: button sync, debounce, edge detect and entry FSM.
// Optional divide-by-zero rejection is enabled by defining ALU_SEQ_DIV_ZERO_GUARD_EN.
module alu_operand_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [1:0]   op_sw,
  input  logic         btn_enter,
  input  logic         btn_clear,
  output logic [N-1:0] firstNum,
  output logic [N-1:0] secNum,
  output logic [1:0]   operation,
  output logic [1:0]   stage,
  output logic         valid,
  output logic         err
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] LOAD_A  = 2'b00;
  localparam logic [1:0] LOAD_B  = 2'b01;
  localparam logic [1:0] LOAD_OP = 2'b10;
  localparam logic [1:0] READY   = 2'b11;

  localparam logic [1:0] OP_DIV  = 2'b10;

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             stable_p2;
  logic             stable_p3;
  logic             press_p3;
  logic [1:0]       state;

  // Stage 0/1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_enter;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p2    <= '0;
      stable_p2 <= 1'b0;
    end else if (sync_p1 != stable_p2) begin
      if (cnt_p2 == CNT_LAST) begin
        stable_p2 <= sync_p1;
        cnt_p2    <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
    end else begin
      cnt_p2 <= '0;
    end
  end

  // Stage 3: registered rising-edge pulse of the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_p3 <= 1'b0;
      press_p3  <= 1'b0;
    end else begin
      stable_p3 <= stable_p2;
      press_p3  <= stable_p2 & ~stable_p3;
    end
  end

  assign stage = state;

`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
  logic div_zero;
  assign div_zero = (op_sw == OP_DIV) && (secNum == '0);
`endif

  // Entry FSM; clear outranks a coincident press, which is dropped
  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      state     <= LOAD_A;
      firstNum  <= '0;
      secNum    <= '0;
      operation <= 2'b00;
      valid     <= 1'b0;
`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
      err       <= 1'b0;
`endif
    end else if (press_p3) begin
      case (state)
        LOAD_A: begin
          firstNum <= sw;
          state    <= LOAD_B;
        end
        LOAD_B: begin
          secNum <= sw;
          state  <= LOAD_OP;
        end
        LOAD_OP: begin
`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
          if (div_zero) begin
            operation <= OP_DIV;
            err       <= 1'b1;
            valid     <= 1'b0;
          end else begin
            operation <= op_sw;
            valid     <= 1'b1;
          end
`else
          operation <= op_sw;
          valid     <= 1'b1;
`endif
          state <= READY;
        end
        default: begin
          // A press in READY restarts entry with the new first operand
          firstNum <= sw;
          valid    <= 1'b0;
`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
          err      <= 1'b0;
`endif
          state    <= LOAD_B;
        end
      endcase
    end
  end

`ifndef ALU_SEQ_DIV_ZERO_GUARD_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a cycle-level reference model and per-cycle compare.
module tb_alu_operand_sequencer;

  localparam int N = 4;
  localparam int D = 4;
`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic [1:0]   op_sw = 2'b00;
  logic         btn_enter = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] firstNum;
  logic [N-1:0] secNum;
  logic [1:0]   operation;
  logic [1:0]   stage;
  logic         valid;
  logic         err;

  alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw),
    .btn_enter(btn_enter), .btn_clear(btn_clear),
    .firstNum(firstNum), .secNum(secNum), .operation(operation),
    .stage(stage), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: sampled-button history, debounced level, press delay, entry rules
  bit sp0, sp1, mst, rp0, rp1;
  int streak;
  int e_a, e_b, e_op, e_stage;
  bit e_valid, e_err;

  always @(posedge clk) begin
    bit sync_v;
    bit press_now;
    if (rst) begin
      sp0 = 0; sp1 = 0; mst = 0; rp0 = 0; rp1 = 0; streak = 0;
      e_a = 0; e_b = 0; e_op = 0; e_stage = 0; e_valid = 0; e_err = 0;
    end else begin
      sync_v = sp1; sp1 = sp0; sp0 = btn_enter;
      press_now = rp1; rp1 = rp0; rp0 = 0;
      if (sync_v != mst) begin
        streak++;
        if (streak == D) begin
          mst = sync_v;
          streak = 0;
          rp0 = sync_v;
        end
      end else begin
        streak = 0;
      end
      if (btn_clear) begin
        e_a = 0; e_b = 0; e_op = 0; e_stage = 0; e_valid = 0; e_err = 0;
      end else if (press_now) begin
        case (e_stage)
          0: begin e_a = int'(sw); e_stage = 1; end
          1: begin e_b = int'(sw); e_stage = 2; end
          2: begin
            if (GUARD && op_sw == 2'b10 && e_b == 0) begin
              e_op = 2; e_err = 1; e_valid = 0;
            end else begin
              e_op = int'(op_sw); e_valid = 1;
            end
            e_stage = 3;
          end
          default: begin e_a = int'(sw); e_valid = 0; e_err = 0; e_stage = 1; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_firstNum", int'(firstNum), e_a);
      chk("cyc_secNum", int'(secNum), e_b);
      chk("cyc_operation", int'(operation), e_op);
      chk("cyc_stage", int'(stage), e_stage);
      chk("cyc_valid", int'(valid), int'(e_valid));
      chk("cyc_err", int'(err), int'(e_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int hold);
    btn_enter = 1'b1;
    tick(hold);
    btn_enter = 1'b0;
    tick(D + 6);
  endtask

  task automatic enter3(input int a, input int b, input int op);
    sw = N'(a); press_btn(D + 2);
    sw = N'(b); press_btn(D + 2);
    op_sw = 2'(op); press_btn(D + 2);
  endtask

  task automatic do_clear();
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    tick(1);
  endtask

  initial begin
    int lat;
    // Reset with the button toggling
    rst = 1'b1;
    btn_enter = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(1);
    rst = 1'b0;
    btn_enter = 1'b0;
    tick(1);
    chk("rst_firstNum", int'(firstNum), 0);
    chk("rst_secNum", int'(secNum), 0);
    chk("rst_operation", int'(operation), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_err", int'(err), 0);
    tick(12);
    chk("rst_no_press_stage", int'(stage), 0);

    // Full entry with latency on the third press
    sw = 4'b0010; press_btn(D + 2);
    sw = 4'b0110; press_btn(D + 2);
    op_sw = 2'b00;
    btn_enter = 1'b1;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (valid) begin
        lat = i;
        break;
      end
    end
    btn_enter = 1'b0;
    tick(D + 6);
    chk("entry_latency", lat, 7);
    chk("entry_firstNum", int'(firstNum), 2);
    chk("entry_secNum", int'(secNum), 6);
    chk("entry_operation", int'(operation), 0);
    chk("entry_valid", int'(valid), 1);
    chk("entry_stage", int'(stage), 3);

    // Bounce rejection, then one clean hold, then a long hold
    do_clear();
    chk("clear_stage", int'(stage), 0);
    sw = 4'd4;
    btn_enter = 1'b1; tick(1); btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(2); btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(3); btn_enter = 1'b0; tick(10);
    chk("bounce_stage", int'(stage), 0);
    press_btn(6);
    chk("hold6_stage", int'(stage), 1);
    chk("hold6_firstNum", int'(firstNum), 4);
    sw = 4'd3;
    press_btn(20);
    chk("longhold_stage", int'(stage), 2);
    chk("longhold_secNum", int'(secNum), 3);

    // Clear in the same cycle as the press: press lands 7 edges after the first sampling edge
    btn_enter = 1'b1;
    tick(7);
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    tick(D + 6);
    chk("clrpri_stage", int'(stage), 0);
    chk("clrpri_firstNum", int'(firstNum), 0);
    chk("clrpri_secNum", int'(secNum), 0);
    chk("clrpri_valid", int'(valid), 0);

    // Re-entry from READY
    enter3(4, 2, 2);
    chk("ready_valid", int'(valid), 1);
    chk("ready_operation", int'(operation), 2);
    sw = 4'b0110; press_btn(D + 2);
    chk("reent_firstNum", int'(firstNum), 6);
    chk("reent_secNum", int'(secNum), 2);
    chk("reent_valid", int'(valid), 0);
    chk("reent_stage", int'(stage), 1);

    // Reserved operation captured unchanged
    sw = 4'd1; press_btn(D + 2);
    op_sw = 2'b11; press_btn(D + 2);
    chk("op11_operation", int'(operation), 3);
    chk("op11_valid", int'(valid), 1);

    // Divide by zero
    do_clear();
    enter3(4, 0, 2);
    chk("div0_stage", int'(stage), 3);
    chk("div0_operation", int'(operation), 2);
`ifdef ALU_SEQ_DIV_ZERO_GUARD_EN
    chk("div0_err", int'(err), 1);
    chk("div0_valid", int'(valid), 0);
`else
    chk("div0_err", int'(err), 0);
    chk("div0_valid", int'(valid), 1);
`endif
    sw = 4'd5; press_btn(D + 2);
    chk("div0_next_err", int'(err), 0);
    chk("div0_next_stage", int'(stage), 1);
    chk("div0_next_firstNum", int'(firstNum), 5);

    // Reset mid-debounce and mid-entry
    btn_enter = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    btn_enter = 1'b0;
    tick(D + 8);
    chk("midrst_stage", int'(stage), 0);
    chk("midrst_firstNum", int'(firstNum), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
